// File: rtl/tone_decoder_if.sv
// tone_decoder_if: signal bundle between the tone decoder and its consumer.
// The decoder side uses the master modport and the consumer side uses the slave modport.
// The period readout signals exist only when TONE_DECODER_PERIOD_OUT_EN is defined.
interface tone_decoder_if;
    logic        tone_in;
    logic [2:0]  note;
    logic        note_valid;
    logic        note_stb;
`ifdef TONE_DECODER_PERIOD_OUT_EN
    logic [17:0] period_meas;
    logic        period_stb;
`endif

`ifdef TONE_DECODER_PERIOD_OUT_EN
    modport master (
        input  tone_in,
        output note,
        output note_valid,
        output note_stb,
        output period_meas,
        output period_stb
    );

    modport slave (
        output tone_in,
        input  note,
        input  note_valid,
        input  note_stb,
        input  period_meas,
        input  period_stb
    );
`else
    modport master (
        input  tone_in,
        output note,
        output note_valid,
        output note_stb
    );

    modport slave (
        output tone_in,
        input  note,
        input  note_valid,
        input  note_stb
    );
`endif
endinterface

// File: rtl/tone_decoder.sv
// tone_decoder: receive-side companion to the square-wave tone generator.
// It measures the period of tone_in in sys_clk cycles and classifies it as one of the notes DO..SI (codes 1..7).
// Code 0 means silence or an unknown period.
// A classification must repeat MATCH_CNT times in a row before it reaches the note output.
// Optional feature macro: TONE_DECODER_PERIOD_OUT_EN.
// When it is defined, the block exposes the last captured period (period_meas) and a capture strobe (period_stb).
module tone_decoder #(
    parameter logic [17:0] DO        = 18'd190839,
    parameter logic [17:0] RE        = 18'd170067,
    parameter logic [17:0] MI        = 18'd151514,
    parameter logic [17:0] FA        = 18'd143265,
    parameter logic [17:0] SO        = 18'd127550,
    parameter logic [17:0] LA        = 18'd113635,
    parameter logic [17:0] SI        = 18'd101213,
    parameter logic [17:0] TOL       = 18'd2000,
    parameter logic [17:0] TIMEOUT   = 18'd250000,
    parameter logic [2:0]  MATCH_CNT = 3'd3
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    tone_decoder_if.master   bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MEAS = 1'b1;

    // Input path
    logic        sync1_r;
    logic        sync2_r;
    logic        sync3_r;
    logic        rise_s;

    // Period measurement
    logic [17:0] cnt_r;
    logic [0:0]  state_r;
    logic [17:0] period_r;
    logic        cap_r;
    logic        timeout_s;

    // Classification and debounce
    logic [2:0]  cls_s;
    logic [2:0]  cand_r;
    logic [2:0]  match_r;
    logic [2:0]  cand_nxt_s;
    logic [2:0]  match_nxt_s;
    logic        commit_s;

    // Registered outputs
    logic [2:0]  note_r;
    logic        valid_r;
    logic        stb_r;

    // True when period lies within +/- tol of (half_cnt + 1).
    // The compare is done in 20 bits with no subtraction, so it cannot overflow or underflow.
    function automatic logic in_window(
        input logic [17:0] period,
        input logic [17:0] half_cnt,
        input logic [17:0] tol
    );
        logic [19:0] p;
        logic [19:0] c;
        logic [19:0] t;
        p = {2'b00, period};
        c = {2'b00, half_cnt} + 20'd1;
        t = {2'b00, tol};
        in_window = ((p + t) >= c) && (p <= (c + t));
    endfunction

    // Single-cycle pulse on each synchronized rising edge of tone_in.
    assign rise_s = sync2_r & ~sync3_r;

    // Counter saturation seen in MEAS without a rise means the tone has gone away.
    assign timeout_s = (state_r == ST_MEAS) && (cnt_r == TIMEOUT) && !rise_s;

    // Two-flop synchronizer on tone_in, plus a history flop for edge detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= bus.tone_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Period counter: clears on each rise and otherwise counts up to TIMEOUT, where it holds without wrapping.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_r <= 18'd0;
        end else if (rise_s) begin
            cnt_r <= 18'd0;
        end else if (cnt_r != TIMEOUT) begin
            cnt_r <= cnt_r + 18'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Measurement FSM.
    // The first rise out of IDLE only arms MEAS.
    // In MEAS, a rise ends the current period; a rise in the same cycle as the timeout wins.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        state_r <= ST_MEAS;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MEAS: begin
                    if (rise_s) begin
                        state_r <= ST_MEAS;
                    end else if (cnt_r == TIMEOUT) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_MEAS;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Capture the period that ends on a rise in MEAS, and flag the capture for one cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            period_r <= 18'd0;
            cap_r    <= 1'b0;
        end else if ((state_r == ST_MEAS) && rise_s) begin
            period_r <= cnt_r + 18'd1;
            cap_r    <= 1'b1;
        end else begin
            period_r <= period_r;
            cap_r    <= 1'b0;
        end
    end

    // Map the captured period to a note code; anything outside every window maps to 0.
    always_comb begin
        cls_s = 3'd0;
        if (in_window(period_r, DO, TOL)) begin
            cls_s = 3'd1;
        end else if (in_window(period_r, RE, TOL)) begin
            cls_s = 3'd2;
        end else if (in_window(period_r, MI, TOL)) begin
            cls_s = 3'd3;
        end else if (in_window(period_r, FA, TOL)) begin
            cls_s = 3'd4;
        end else if (in_window(period_r, SO, TOL)) begin
            cls_s = 3'd5;
        end else if (in_window(period_r, LA, TOL)) begin
            cls_s = 3'd6;
        end else if (in_window(period_r, SI, TOL)) begin
            cls_s = 3'd7;
        end else begin
            cls_s = 3'd0;
        end
    end

    // Next candidate and run length after the current classification.
    // commit_s is set when the run reaches MATCH_CNT on a new value.
    always_comb begin
        cand_nxt_s  = cand_r;
        match_nxt_s = match_r;
        commit_s    = 1'b0;
        if (cls_s == cand_r) begin
            cand_nxt_s = cand_r;
            if (match_r >= MATCH_CNT) begin
                match_nxt_s = MATCH_CNT;
            end else begin
                match_nxt_s = match_r + 3'd1;
            end
        end else begin
            cand_nxt_s  = cls_s;
            match_nxt_s = 3'd1;
        end
        if (cap_r && !timeout_s && (match_nxt_s == MATCH_CNT) && (cand_nxt_s != note_r)) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Debounce state: a timeout forgets the candidate, and each capture advances it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cand_r  <= 3'd0;
            match_r <= 3'd0;
        end else if (timeout_s) begin
            cand_r  <= 3'd0;
            match_r <= 3'd0;
        end else if (cap_r) begin
            cand_r  <= cand_nxt_s;
            match_r <= match_nxt_s;
        end else begin
            cand_r  <= cand_r;
            match_r <= match_r;
        end
    end

    // Output registers.
    // A timeout silences a sounding note; a debounced new value replaces note.
    // note_stb marks each real change of note.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            note_r  <= 3'd0;
            valid_r <= 1'b0;
            stb_r   <= 1'b0;
        end else if (timeout_s) begin
            if (note_r != 3'd0) begin
                note_r  <= 3'd0;
                valid_r <= 1'b0;
                stb_r   <= 1'b1;
            end else begin
                note_r  <= note_r;
                valid_r <= valid_r;
                stb_r   <= 1'b0;
            end
        end else if (commit_s) begin
            note_r  <= cand_nxt_s;
            valid_r <= (cand_nxt_s != 3'd0);
            stb_r   <= 1'b1;
        end else begin
            note_r  <= note_r;
            valid_r <= valid_r;
            stb_r   <= 1'b0;
        end
    end

    assign bus.note       = note_r;
    assign bus.note_valid = valid_r;
    assign bus.note_stb   = stb_r;

`ifdef TONE_DECODER_PERIOD_OUT_EN
    // period_r and cap_r are already registered and reset to zero, so they drive the readout directly.
    assign bus.period_meas = period_r;
    assign bus.period_stb  = cap_r;
`endif

endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: directed, table-driven bench for tone_decoder.
// The note periods are scaled down about 1000x so the run stays short; the window and debounce rules are unchanged.
// Scaled nominal periods are DO 191, RE 171, MI 152, FA 144, SO 128, LA 114 and SI 102.
// TOL is 2 and TIMEOUT is 250.
module tb_tone_decoder;

    logic sys_clk;
    logic sys_rst_n;

    tone_decoder_if bus ();

    tone_decoder #(
        .DO        (18'd190),
        .RE        (18'd170),
        .MI        (18'd151),
        .FA        (18'd143),
        .SO        (18'd127),
        .LA        (18'd113),
        .SI        (18'd101),
        .TOL       (18'd2),
        .TIMEOUT   (18'd250),
        .MATCH_CNT (3'd3)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    typedef struct {
        string    name;
        int       period;
        int       count;
        int       exp_note;
        int       exp_stb;
    } vec_t;

    vec_t vecs [11];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stb_count = 0;
    int last_stb_cyc = -1;
    int dbl_stb = 0;
    logic prev_stb = 1'b0;
    int rise_log [8];

    // 100 MHz bench clock.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Free-running cycle index used to time strobes.
    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
    end

    // Strobe monitor, sampled on the falling edge.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (bus.note_stb) begin
                stb_count    <= stb_count + 1;
                last_stb_cyc <= cyc;
                if (prev_stb) begin
                    dbl_stb <= dbl_stb + 1;
                end
            end
            prev_stb <= bus.note_stb;
        end else begin
            prev_stb <= 1'b0;
        end
    end

    // Hard bound on run time.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int m);
        repeat (m) @(posedge sys_clk);
        #1;
    endtask

    // n full periods of p clocks at 50% duty; the rising edge comes first.
    task automatic tone_periods(input int p, input int n);
        for (int k = 0; k < n; k++) begin
            if (k < 8) begin
                rise_log[k] = cyc;
            end
            bus.tone_in = 1'b1;
            wait_clks(p / 2);
            bus.tone_in = 1'b0;
            wait_clks(p - (p / 2));
        end
    endtask

    task automatic apply_vec(input int i);
        int s0;
        s0 = stb_count;
        tone_periods(vecs[i].period, vecs[i].count);
        chk({vecs[i].name, "_note"}, int'(bus.note), vecs[i].exp_note);
        chk({vecs[i].name, "_valid"}, int'(bus.note_valid), (vecs[i].exp_note != 0) ? 1 : 0);
        chk({vecs[i].name, "_stb"}, stb_count - s0, vecs[i].exp_stb);
    endtask

    initial begin
        int s0;

        vecs[0]  = '{"so_hold",     128, 3, 1, 0};
        vecs[1]  = '{"so_lock",     128, 1, 5, 1};
        vecs[2]  = '{"mi_lock",     152, 4, 3, 1};
        vecs[3]  = '{"glitch",       40, 1, 3, 0};
        vecs[4]  = '{"mi_resume",   152, 4, 3, 0};
        vecs[5]  = '{"la_lock",     114, 4, 6, 1};
        vecs[6]  = '{"si_over_tol", 105, 6, 0, 0};
        vecs[7]  = '{"si_hi_edge",  104, 4, 7, 1};
        vecs[8]  = '{"si_under",     99, 4, 0, 1};
        vecs[9]  = '{"si_lo_edge",  100, 4, 7, 1};
        vecs[10] = '{"re_lock",     171, 4, 2, 1};

        // Reset state
        sys_rst_n   = 1'b0;
        bus.tone_in = 1'b0;
        wait_clks(5);
        chk("rst_note", int'(bus.note), 0);
        chk("rst_valid", int'(bus.note_valid), 0);
        chk("rst_stb", int'(bus.note_stb), 0);
        sys_rst_n = 1'b1;
        wait_clks(3);

        // DO lock: the first rise only arms, the 4th rise commits, and the 5th rise stays quiet.
        s0 = stb_count;
        tone_periods(191, 5);
        chk("do_note", int'(bus.note), 1);
        chk("do_valid", int'(bus.note_valid), 1);
        chk("do_stb_count", stb_count - s0, 1);
        chk("do_stb_time", last_stb_cyc, rise_log[3] + 4);

        for (int i = 0; i < 6; i++) begin
            apply_vec(i);
        end

        // Hold the input low after the LA lock: the timeout silences the note with one strobe.
        s0 = stb_count;
        wait_clks(300);
        chk("to_note", int'(bus.note), 0);
        chk("to_valid", int'(bus.note_valid), 0);
        chk("to_stb", stb_count - s0, 1);

        // A lone edge from IDLE only re-arms, then times out quietly.
        s0 = stb_count;
        bus.tone_in = 1'b1;
        wait_clks(50);
        bus.tone_in = 1'b0;
        wait_clks(300);
        chk("lone_edge_note", int'(bus.note), 0);
        chk("lone_edge_stb", stb_count - s0, 0);

        for (int i = 6; i < 11; i++) begin
            apply_vec(i);
        end

`ifdef TONE_DECODER_PERIOD_OUT_EN
        chk("period_meas", int'(bus.period_meas), 171);
`endif

        // Reset in the middle of a period while locked on RE.
        bus.tone_in = 1'b1;
        wait_clks(50);
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_note", int'(bus.note), 0);
        chk("midrst_valid", int'(bus.note_valid), 0);
        chk("midrst_stb", int'(bus.note_stb), 0);
        bus.tone_in = 1'b0;
        wait_clks(4);
        sys_rst_n = 1'b1;
        wait_clks(20);

        // After release, RE needs MATCH_CNT+1 rises to lock again.
        s0 = stb_count;
        tone_periods(171, 3);
        chk("relock_hold_note", int'(bus.note), 0);
        chk("relock_hold_stb", stb_count - s0, 0);
        tone_periods(171, 1);
        chk("relock_note", int'(bus.note), 2);
        chk("relock_stb", stb_count - s0, 1);

        chk("no_back_to_back_stb", dbl_stb, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
